// File: rtl/multichannel_cascaded_moving_average.sv
// N-channel cascaded boxcar (running-sum) filter with clear sequencing, settled and dropped-sample flags.
// Optional integrate-and-dump decimation by L is enabled with `define MA_DECIMATION_EN.
module multichannel_cascaded_moving_average #(
  parameter int NUM_CHANNELS     = 2,
  parameter int MAX_DECIMATION   = 1024,
  parameter int INPUT_DATA_BITS  = 32,
  parameter int OUTPUT_DATA_BITS = 64,
  parameter int MAX_CASCADED_MAs = 3,
  parameter int SIGNED           = 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  output logic                                      ready,
  input  logic [NUM_CHANNELS*INPUT_DATA_BITS-1:0]   data_in,
  input  logic                                      data_in_valid,
  input  logic [$clog2(MAX_DECIMATION):0]           length_moving_average,
  input  logic [$clog2(MAX_CASCADED_MAs):0]         order_rolloff,
  output logic [NUM_CHANNELS*OUTPUT_DATA_BITS-1:0]  data_out,
  output logic                                      data_out_valid,
  output logic                                      settled,
  output logic                                      sample_dropped,
  output logic                                      dbg_state_o
);
  localparam int AW = $clog2(MAX_DECIMATION);
  localparam int LW = AW + 1;
  localparam int KW = $clog2(MAX_CASCADED_MAs) + 1;
  localparam int M  = MAX_CASCADED_MAs;
  localparam int NC = NUM_CHANNELS;
  localparam int IW = INPUT_DATA_BITS;
  localparam int OW = OUTPUT_DATA_BITS;
  localparam int CW = LW + KW;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q;
  logic [AW-1:0]           clr_q;
  logic [LW-1:0]           len_q, len_cl;
  logic [KW-1:0]           ord_q, ord_cl;
  logic [M-1:0]            vld_q;
  logic [AW-1:0]           ptr_q [M];
  logic [OW-1:0]           acc_q [NC][M];
  logic [OW-1:0]           dly_mem [NC][M][MAX_DECIMATION];
  logic [CW-1:0]           out_cnt_q, settle_tgt;
  logic [NC*OW-1:0]        dout_q;
  logic                    dvalid_q, settled_q, dropped_q;
  logic                    cfg_change, accept, dec_hit;
  logic [M-1:0]            stg_vld;
  logic [OW-1:0]           stg_in  [NC][M];
  logic [OW-1:0]           stg_old [NC][M];

  always_comb begin
    len_cl = length_moving_average;
    if (length_moving_average == '0) len_cl = LW'(1);
    else if (length_moving_average > LW'(MAX_DECIMATION)) len_cl = LW'(MAX_DECIMATION);
    ord_cl = order_rolloff;
    if (order_rolloff == '0) ord_cl = KW'(1);
    else if (order_rolloff > KW'(MAX_CASCADED_MAs)) ord_cl = KW'(MAX_CASCADED_MAs);
  end

  // Handshake: a sample is taken on a clock edge iff data_in_valid && ready in that cycle;
  // valid while ready is low is discarded and recorded in sample_dropped. There is no backpressure.
  assign cfg_change = (state_q == ST_RUN) && ((len_cl != len_q) || (ord_cl != ord_q));
  assign ready      = (state_q == ST_RUN) && !cfg_change;
  assign accept     = ready && data_in_valid;
  assign settle_tgt = CW'(ord_q) * CW'(len_q - LW'(1));

  always_comb begin
    stg_vld    = '0;
    stg_vld[0] = accept;
    for (int s = 1; s < M; s++) stg_vld[s] = vld_q[s-1];
    for (int c = 0; c < NC; c++) begin
      stg_in[c][0] = {{(OW-IW){(SIGNED != 0) && data_in[c*IW+IW-1]}}, data_in[c*IW +: IW]};
      for (int s = 1; s < M; s++) stg_in[c][s] = acc_q[c][s-1];
      for (int s = 0; s < M; s++) stg_old[c][s] = dly_mem[c][s][ptr_q[s]];
    end
  end

`ifdef MA_DECIMATION_EN
  logic [LW-1:0] dec_q;
  assign dec_hit = (dec_q == len_q - LW'(1));
`else
  assign dec_hit = 1'b1;
`endif

  // Delay lines carry no reset; the CLEAR sweep zeroes one address per cycle instead.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NC; c++) begin
      for (int s = 0; s < M; s++) begin
        if (state_q == ST_CLEAR) dly_mem[c][s][clr_q] <= '0;
        else if (stg_vld[s]) dly_mem[c][s][ptr_q[s]] <= stg_in[c][s];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_q     <= '0;
      len_q     <= LW'(1);
      ord_q     <= KW'(1);
      vld_q     <= '0;
      out_cnt_q <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      settled_q <= 1'b0;
      dropped_q <= 1'b0;
`ifdef MA_DECIMATION_EN
      dec_q     <= '0;
`endif
      for (int s = 0; s < M; s++) ptr_q[s] <= '0;
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < M; s++) acc_q[c][s] <= '0;
    end else begin
      dvalid_q <= 1'b0;
      if (data_in_valid && !ready) dropped_q <= 1'b1;
      if (state_q == ST_CLEAR) begin
        clr_q     <= clr_q + AW'(1);
        vld_q     <= '0;
        out_cnt_q <= '0;
        dout_q    <= '0;
        settled_q <= 1'b0;
`ifdef MA_DECIMATION_EN
        dec_q     <= '0;
`endif
        for (int s = 0; s < M; s++) ptr_q[s] <= '0;
        for (int c = 0; c < NC; c++)
          for (int s = 0; s < M; s++) acc_q[c][s] <= '0;
        if (clr_q == AW'(MAX_DECIMATION - 1)) begin
          state_q <= ST_RUN;
          len_q   <= len_cl;
          ord_q   <= ord_cl;
        end
      end else if (cfg_change) begin
        // In-flight samples are abandoned; the sweep rebuilds all state from zero.
        state_q   <= ST_CLEAR;
        clr_q     <= '0;
        vld_q     <= '0;
        dout_q    <= '0;
        settled_q <= 1'b0;
      end else begin
        vld_q[0] <= accept;
        for (int s = 1; s < M; s++) vld_q[s] <= vld_q[s-1];
        for (int s = 0; s < M; s++) begin
          if (stg_vld[s]) begin
            ptr_q[s] <= (LW'(ptr_q[s]) == len_q - LW'(1)) ? '0 : ptr_q[s] + AW'(1);
            for (int c = 0; c < NC; c++)
              acc_q[c][s] <= (KW'(s) < ord_q) ? acc_q[c][s] + stg_in[c][s] - stg_old[c][s]
                                              : stg_in[c][s];
          end
        end
        if (vld_q[M-1]) begin
          if (out_cnt_q < settle_tgt) out_cnt_q <= out_cnt_q + CW'(1);
          if (out_cnt_q >= settle_tgt) settled_q <= 1'b1;
`ifdef MA_DECIMATION_EN
          dec_q <= dec_hit ? '0 : dec_q + LW'(1);
`endif
          if (dec_hit) begin
            dvalid_q <= 1'b1;
            for (int c = 0; c < NC; c++) dout_q[c*OW +: OW] <= acc_q[c][M-1];
          end
        end
      end
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dvalid_q;
  assign settled        = settled_q;
  assign sample_dropped = dropped_q;
  assign dbg_state_o    = (state_q == ST_RUN);
endmodule

// File: tb/tb_multichannel_cascaded_moving_average.sv
// Randomized scoreboard bench for multichannel_cascaded_moving_average against a windowed-sum model.
module tb_multichannel_cascaded_moving_average;
  localparam int NC = 2, IW = 32, OW = 64, MAXD = 1024, MAXK = 3, LAT = MAXK + 1;
  localparam int EW = NC*OW + 32 + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ready;
  logic [NC*IW-1:0]  data_in = '0;
  logic              data_in_valid = 1'b0;
  logic [10:0]       length_moving_average = 11'd4;
  logic [2:0]        order_rolloff = 3'd1;
  logic [NC*OW-1:0]  data_out;
  logic              data_out_valid, settled, sample_dropped, dbg_state;

  multichannel_cascaded_moving_average dut (
    .clock(clock), .reset(reset), .ready(ready), .data_in(data_in),
    .data_in_valid(data_in_valid), .length_moving_average(length_moving_average),
    .order_rolloff(order_rolloff), .data_out(data_out), .data_out_valid(data_out_valid),
    .settled(settled), .sample_dropped(sample_dropped), .dbg_state_o(dbg_state)
  );

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  bit        m_run, m_drop;
  int        m_clr_left, m_len = 1, m_ord = 1, m_n;
  int        nxt_len = 4, nxt_ord = 1;
  logic [OW-1:0] seq [NC][MAXK+1][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    return (l == 0) ? 1 : ((l > MAXD) ? MAXD : l);
  endfunction
  function automatic int clamp_ord(input int k);
    return (k == 0) ? 1 : ((k > MAXK) ? MAXK : k);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s <= MAXK; s++) seq[c][s].delete();
    m_n = 0; m_run = 0; m_clr_left = MAXD;
  endtask

  // Output n of stage s is the sum of the last L outputs of stage s-1 (zero before the clear).
  task automatic model_push(input logic [NC*IW-1:0] d);
    logic [NC*OW-1:0] outv;
    logic [OW-1:0]    acc, x;
    logic [IW-1:0]    smp;
    bit               emit, stl;
    outv = '0;
    for (int c = 0; c < NC; c++) begin
      smp = d[c*IW +: IW];
      x = {{(OW-IW){smp[IW-1]}}, smp};
      seq[c][0].push_back(x);
      for (int s = 1; s <= m_ord; s++) begin
        acc = '0;
        for (int j = 0; j < m_len; j++)
          if (m_n - j >= 0) acc += seq[c][s-1][m_n-j];
        seq[c][s].push_back(acc);
      end
      outv[c*OW +: OW] = seq[c][m_ord][m_n];
    end
    stl = (m_n >= m_ord * (m_len - 1));
`ifdef MA_DECIMATION_EN
    emit = ((m_n % m_len) == m_len - 1);
`else
    emit = 1'b1;
`endif
    if (emit) exp_q.push_back({stl, 32'(cyc + LAT), outv});
    m_n++;
  endtask

  task automatic eval_cycle();
    bit chg, exp_rdy;
    logic [EW-1:0] e;
    chg = m_run && ((clamp_len(int'(length_moving_average)) != m_len) ||
                    (clamp_ord(int'(order_rolloff)) != m_ord));
    exp_rdy = m_run && !chg;
    check("ready", 128'(ready), 128'(exp_rdy));
    check("sample_dropped", 128'(sample_dropped), 128'(m_drop));
    if (data_in_valid && !exp_rdy) m_drop = 1;
    if (data_in_valid && exp_rdy) model_push(data_in);
    if (chg) begin
      while (exp_q.size() > 0) begin
        e = exp_q[exp_q.size()-1];
        if (e[NC*OW +: 32] > 32'(cyc)) void'(exp_q.pop_back());
        else break;
      end
      model_clear();
    end else if (!m_run) begin
      if (m_clr_left == 1) begin
        m_run = 1;
        m_len = clamp_len(int'(length_moving_average));
        m_ord = clamp_ord(int'(order_rolloff));
      end
      m_clr_left--;
    end
  endtask

  task automatic step(input bit v, input logic [IW-1:0] a, input logic [IW-1:0] b);
    @(posedge clock);
    #2;
    data_in_valid = v;
    data_in = {b, a};
    length_moving_average = 11'(nxt_len);
    order_rolloff = 3'(nxt_ord);
    #2;
    eval_cycle();
  endtask

  task automatic do_reset();
    int z;
    @(posedge clock);
    #2;
    reset = 1'b0;
    data_in_valid = 1'b0;
    exp_q.delete();
    model_clear();
    m_drop = 0;
    #1;
    check("rst_data_out", data_out, 128'd0);
    check("rst_valid", 128'(data_out_valid), 128'd0);
    check("rst_ready", 128'(ready), 128'd0);
    check("rst_settled", 128'(settled), 128'd0);
    check("rst_dropped", 128'(sample_dropped), 128'd0);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    length_moving_average = 11'(nxt_len);
    order_rolloff = 3'(nxt_ord);
    #2;
    eval_cycle();
    z = ready ? 0 : 1;
    while (!ready && z < 2000) begin
      step(0, '0, '0);
      if (!ready) z++;
    end
    check("ready_low_after_reset", 128'(z), 128'd1024);
  endtask

  task automatic wait_clear();
    for (int i = 0; i < MAXD + 4 && !m_run; i++) step(0, '0, '0);
  endtask

  task automatic drain();
    repeat (LAT + 2) step(0, '0, '0);
  endtask

  // monitor: pops one expectation per presented output
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #7;
      while (exp_q.size() > 0) begin
        e = exp_q[0];
        if (e[NC*OW +: 32] < 32'(cyc)) begin
          n_vec++; n_err++;
          $display("FAIL missing_output @cyc %0d: no data_out_valid, expected %0h", cyc, e[NC*OW-1:0]);
          void'(exp_q.pop_front());
        end else break;
      end
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output @cyc %0d: got %0h expected no output", cyc, data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, 128'(e[NC*OW-1:0]));
          check("out_latency_cycle", 128'(cyc), 128'(e[NC*OW +: 32]));
          check("settled", 128'(settled), 128'(e[EW-1]));
        end
      end
    end
  end

  initial begin
    int z;
    nxt_len = 4; nxt_ord = 1;
    do_reset();

    // constants +1 / -1, L=4 K=1
    for (int i = 0; i < 10; i++) step(1, 32'd1, 32'hffff_ffff);
    drain();

    // impulse, L=2 K=3
    nxt_len = 2; nxt_ord = 3;
    step(0, '0, '0);
    wait_clear();
    step(1, 32'd1, 32'd5);
    for (int i = 0; i < 8; i++) step(1, '0, '0);
    drain();

    // streaming L change 4 -> 8
    nxt_len = 4; nxt_ord = 1;
    step(0, '0, '0);
    wait_clear();
    for (int i = 0; i < 20; i++) step(1, $urandom, $urandom);
    nxt_len = 8;
    step(1, $urandom, $urandom);
    z = ready ? 0 : 1;
    step(1, $urandom, $urandom);
    if (!ready) z++;
    check("settled_after_cfg_change", 128'(settled), 128'd0);
    check("data_out_after_cfg_change", data_out, 128'd0);
    while (!ready && z < 2000) begin
      step(1, $urandom, $urandom);
      if (!ready) z++;
    end
    check("ready_low_after_cfg_change", 128'(z), 128'd1025);
    for (int i = 0; i < 20; i++) step(1, $urandom, $urandom);
    drain();

    // clamping: L=0 -> 1, K=7 -> 3
    nxt_len = 0; nxt_ord = 7;
    step(0, '0, '0);
    wait_clear();
    for (int i = 0; i < 16; i++) step(1, $urandom, $urandom);
    drain();

    // ramp 1..12 at L=4 K=1
    nxt_len = 4; nxt_ord = 1;
    step(0, '0, '0);
    wait_clear();
    for (int i = 1; i <= 12; i++) step(1, 32'(i), 32'(-i));
    drain();

    // random configurations with gapped valid
    repeat (5) begin
      nxt_len = $urandom_range(1, 12);
      nxt_ord = $urandom_range(0, 3);
      step(0, '0, '0);
      wait_clear();
      for (int i = 0; i < 40; i++) step($urandom_range(0, 3) != 0, $urandom, $urandom);
      drain();
    end

    // asynchronous reset in the middle of a stream
    nxt_len = 3; nxt_ord = 2;
    step(0, '0, '0);
    wait_clear();
    for (int i = 0; i < 10; i++) step(1, $urandom, $urandom);
    do_reset();
    for (int i = 0; i < 12; i++) step(1, $urandom, $urandom);
    drain();

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
